// File: rtl/uart_rx_core_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and baud divider math.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_rx_core_pkg;

   // Receiver framing states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   // Clocks per oversample tick. Integer divide, identical to the TX-side tick generator.
   function automatic int unsigned calc_div(input int unsigned freq,
                                            input int unsigned baud,
                                            input int unsigned oversample);
      return freq / (baud * oversample);
   endfunction

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO with first-word fall-through read port.
// Latency: a written word is visible on read_data the clock after the write.
// Backpressure: writes while full are dropped; reads while empty are ignored.
module fifo #(
   parameter int data_size   = 8,
   parameter int buffer_size = 64
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               write_en,
   input  logic [data_size-1:0]               write_data,
   input  logic                               read_en,
   output logic [data_size-1:0]               read_data,
   output logic                               empty,
   output logic                               full,
   output logic [$clog2(buffer_size+1)-1:0]   count
);

   localparam int AW = (buffer_size > 1) ? $clog2(buffer_size) : 1;
   localparam int CW = $clog2(buffer_size + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(buffer_size);

   logic [data_size-1:0] mem [buffer_size];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic                 do_wr;
   logic                 do_rd;

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);
   assign do_wr = write_en && !full;
   assign do_rd = read_en && !empty;

   // Storage array; contents are only observable through valid pointers, so no reset.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= write_data;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_wr, do_rd})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Head word presented combinationally; forced to zero when nothing is held.
   assign read_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/rx_oversample_tick_generator.sv
// Oversample tick source: one-clock tick every DIV clocks, phase restarted by clear.
// Latency: first tick DIV clocks after clear drops.
// Backpressure: none; free-running while clear is low.
module rx_oversample_tick_generator #(
   parameter int unsigned DIV = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] div_cnt;

   // Divider counter; clear holds it at zero so the first tick lands DIV clocks after release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (clear || (div_cnt == LAST)) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + CW'(1);
      end
   end

   assign tick = !clear && (div_cnt == LAST);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronizes rx, deframes start/data/stop (LSB first), buffers bytes in a FIFO.
// Latency: byte appears on data_out/data_valid 1 clk after the last stop-bit mid-sample.
// Backpressure: none on the line; a good byte arriving with the FIFO full is dropped and flagged.
module uart_rx_core
   import uart_rx_core_pkg::*;
#(
   parameter int          NO_OF_DATABITS = 8,
   parameter int          NO_OF_STOPBITS = 1,
   parameter logic [31:0] BAUDRATE       = 32'd9600,
   parameter logic [31:0] FREQUENCY      = 32'd100000000,
   parameter int          OVERSAMPLE     = 16,
   parameter int          FIFO_DEPTH     = 64
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              rx,
   input  logic                              read_data,
   input  logic                              clear_errors,
   output logic [NO_OF_DATABITS-1:0]         data_out,
   output logic                              data_valid,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic                              busy,
   output logic                              framing_error,
   output logic                              overflow
);

   localparam int unsigned DIV = calc_div(FREQUENCY, BAUDRATE, OVERSAMPLE);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (NO_OF_DATABITS > 2) ? $clog2(NO_OF_DATABITS) : 1;
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(NO_OF_DATABITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(NO_OF_STOPBITS - 1);

   logic [1:0]                rx_sync;
   logic                      rx_s;
   logic                      tick;
   rx_state_t                 state;
   rx_state_t                 state_n;
   logic [TW-1:0]             tick_cnt;
   logic [TW-1:0]             tick_cnt_n;
   logic [BW-1:0]             bit_cnt;
   logic [BW-1:0]             bit_cnt_n;
   logic [NO_OF_DATABITS-1:0] shift_reg;
   logic [NO_OF_DATABITS-1:0] shift_n;
   logic                      push;
   logic                      frame_err_evt;
   logic                      fifo_empty;
   logic                      fifo_full;
   logic                      ovf_evt;

   // Two-flop synchronizer; idles at 1 so reset never looks like a start edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_sync <= 2'b11;
      end else begin
         rx_sync <= {rx_sync[0], rx};
      end
   end

   assign rx_s = rx_sync[1];

   // Tick phase restarts on every start edge because the divider is held in IDLE.
   rx_oversample_tick_generator #(
      .DIV (DIV)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .clear (state == IDLE),
      .tick  (tick)
   );

   // Framing state and counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else begin
         state     <= state_n;
         tick_cnt  <= tick_cnt_n;
         bit_cnt   <= bit_cnt_n;
         shift_reg <= shift_n;
      end
   end

   // Next-state logic: mid-bit sampling on tick counts, push or error on the stop bit.
   always_comb begin
      state_n       = state;
      tick_cnt_n    = tick_cnt;
      bit_cnt_n     = bit_cnt;
      shift_n       = shift_reg;
      push          = 1'b0;
      frame_err_evt = 1'b0;
      case (state)
         IDLE: begin
            tick_cnt_n = '0;
            bit_cnt_n  = '0;
            if (!rx_s) begin
               state_n = START;
            end
         end
         START: begin
            if (tick) begin
               if (tick_cnt == TICK_MID) begin
                  tick_cnt_n = '0;
                  bit_cnt_n  = '0;
                  // A line back high at mid start bit was a glitch, not a frame.
                  state_n    = rx_s ? IDLE : DATA;
               end else begin
                  tick_cnt_n = tick_cnt + TW'(1);
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (tick_cnt == TICK_LAST) begin
                  tick_cnt_n = '0;
                  shift_n    = NO_OF_DATABITS'({rx_s, shift_reg} >> 1);
                  if (bit_cnt == DATA_LAST) begin
                     bit_cnt_n = '0;
                     state_n   = STOP;
                  end else begin
                     bit_cnt_n = bit_cnt + BW'(1);
                  end
               end else begin
                  tick_cnt_n = tick_cnt + TW'(1);
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (tick_cnt == TICK_LAST) begin
                  tick_cnt_n = '0;
                  if (!rx_s) begin
                     frame_err_evt = 1'b1;
                     state_n       = IDLE;
                  end else if (bit_cnt == STOP_LAST) begin
                     // Leave at mid stop bit so an immediately following start edge is caught.
                     push    = 1'b1;
                     state_n = IDLE;
                  end else begin
                     bit_cnt_n = bit_cnt + BW'(1);
                  end
               end else begin
                  tick_cnt_n = tick_cnt + TW'(1);
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   fifo #(
      .data_size   (NO_OF_DATABITS),
      .buffer_size (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .write_en   (push),
      .write_data (shift_reg),
      .read_en    (read_data),
      .read_data  (data_out),
      .empty      (fifo_empty),
      .full       (fifo_full),
      .count      (fifo_count)
   );

   assign ovf_evt    = push && fifo_full;
   assign data_valid = !fifo_empty;
   assign busy       = (state != IDLE);

   // Sticky error flags; a new event in the clear cycle keeps the flag set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         framing_error <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         framing_error <= frame_err_evt | (framing_error & ~clear_errors);
         overflow      <= ovf_evt | (overflow & ~clear_errors);
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomized scoreboard bench for uart_rx_core: serial frames in, popped bytes checked against a queue model.
// Latency: n/a.
// Backpressure: reader pops randomly when enabled, or at a scheduled cycle.
module tb_uart_rx_core;

   localparam int FREQ  = 16000;
   localparam int BAUD  = 100;
   localparam int OS    = 16;
   localparam int DEPTH = 4;
   localparam int BIT   = FREQ / BAUD;
   localparam int CW    = $clog2(DEPTH + 1);
   // Start edge driven after posedge N is sampled mid stop bit at posedge N + 3 + DIV*(OS/2 + 9*OS).
   localparam int STOP_SAMPLE = 3 + (FREQ / (BAUD * OS)) * (OS / 2 + 9 * OS);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          rx = 1'b1;
   logic          read_data = 1'b0;
   logic          clear_errors = 1'b0;
   logic [7:0]    data_out;
   logic          data_valid;
   logic [CW-1:0] fifo_count;
   logic          busy;
   logic          framing_error;
   logic          overflow;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         pop_at = -1;
   int         clr_at = -1;
   bit         rd_on = 1'b0;
   bit         exp_fe = 1'b0;
   bit         exp_ovf = 1'b0;
   logic [7:0] exp_q[$];

   uart_rx_core #(
      .NO_OF_DATABITS (8),
      .NO_OF_STOPBITS (1),
      .BAUDRATE       (BAUD),
      .FREQUENCY      (FREQ),
      .OVERSAMPLE     (OS),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .rx            (rx),
      .read_data     (read_data),
      .clear_errors  (clear_errors),
      .data_out      (data_out),
      .data_valid    (data_valid),
      .fifo_count    (fifo_count),
      .busy          (busy),
      .framing_error (framing_error),
      .overflow      (overflow)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // Monitor: sole driver of read_data/clear_errors; every pop is compared with the model head.
   initial begin
      forever begin
         @(negedge clk);
         read_data    = 1'b0;
         clear_errors = (cyc == clr_at);
         if (pop_at >= 0 && cyc == pop_at + 1) begin
            check("count_push_pop", fifo_count, exp_q.size());
            pop_at = -1;
         end
         if (!reset && data_valid && ((rd_on && $urandom_range(1, 0) == 1) || cyc == pop_at)) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got %0h, expected no data", data_out);
            end else begin
               check("data_out", data_out, exp_q.pop_front());
            end
            read_data = 1'b1;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive one 8N1 frame; the model learns the outcome when the stop bit begins.
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit pop_in_push,
                             input bit clr_in_stop);
      @(negedge clk);
      rx = 1'b0;
      if (pop_in_push) pop_at = cyc + STOP_SAMPLE - 1;
      if (clr_in_stop) clr_at = cyc + STOP_SAMPLE - 1;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT) @(negedge clk);
      end
      if (stop_ok) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(b);
         else exp_ovf = 1'b1;
      end else begin
         exp_fe = 1'b1;
      end
      rx = stop_ok;
      repeat (BIT) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic clear_flags();
      @(negedge clk);
      clr_at = cyc + 1;
      repeat (3) @(negedge clk);
      exp_fe  = 1'b0;
      exp_ovf = 1'b0;
      check("fe_cleared", framing_error, exp_fe);
      check("ovf_cleared", overflow, exp_ovf);
   endtask

   task automatic drain(input string name);
      int n = 0;
      rd_on = 1'b1;
      while (exp_q.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: %0d bytes never delivered, expected 0", name, exp_q.size());
      end
      repeat (3) @(negedge clk);
      check({name, "_count"}, fifo_count, 0);
      check({name, "_valid"}, data_valid, 0);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_data_out"}, data_out, 0);
      check({name, "_valid"}, data_valid, 0);
      check({name, "_count"}, fifo_count, 0);
      check({name, "_busy"}, busy, 0);
      check({name, "_fe"}, framing_error, 0);
      check({name, "_ovf"}, overflow, 0);
   endtask

   initial begin
      logic [7:0] b;
      idle(5);
      check_all_zero("reset");
      reset = 1'b0;
      idle(20);

      // Single good frame
      send_frame(8'h55, 1'b1, 1'b0, 1'b0);
      idle(BIT);
      check("t1_valid", data_valid, exp_q.size() != 0);
      check("t1_data", data_out, exp_q[0]);
      check("t1_count", fifo_count, exp_q.size());
      check("t1_fe", framing_error, exp_fe);
      check("t1_ovf", overflow, exp_ovf);
      drain("t1");
      rd_on = 1'b0;

      // Start-bit glitch
      @(negedge clk);
      rx = 1'b0;
      idle(20);
      check("t2_busy_mid", busy, 1);
      idle(20);
      rx = 1'b1;
      idle(100);
      check("t2_busy_end", busy, 0);
      check("t2_count", fifo_count, exp_q.size());
      check("t2_fe", framing_error, exp_fe);

      // Bad stop bit with clear_errors landing on the error cycle
      send_frame(8'hA3, 1'b0, 1'b0, 1'b1);
      idle(BIT);
      check("t3_fe", framing_error, exp_fe);
      check("t3_count", fifo_count, exp_q.size());
      check("t3_busy", busy, 0);
      clear_flags();

      // Overflow: five bytes into a four-deep buffer
      for (int i = 0; i < 5; i++) begin
         b = 8'(i);
         send_frame(b, 1'b1, 1'b0, 1'b0);
         idle(BIT);
      end
      check("t4_count", fifo_count, exp_q.size());
      check("t4_ovf", overflow, exp_ovf);
      check("t4_head", data_out, exp_q[0]);
      drain("t4");
      rd_on = 1'b0;
      clear_flags();

      // Pop coinciding with push at count 2
      for (int i = 0; i < 2; i++) begin
         send_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
         idle(BIT);
      end
      check("t5_count_before", fifo_count, exp_q.size());
      send_frame(8'hC7, 1'b1, 1'b1, 1'b0);
      idle(BIT);
      check("t5_count_after", fifo_count, exp_q.size());
      drain("t5");
      rd_on = 1'b0;

      // Reset during data bit 4 with stale state present
      send_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
      idle(BIT);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
      idle(BIT);
      check("t6_pre_count", fifo_count, exp_q.size());
      check("t6_pre_fe", framing_error, exp_fe);
      b = 8'h96;
      @(negedge clk);
      rx = 1'b0;
      idle(BIT);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         idle(BIT);
      end
      rx = b[4];
      idle(BIT / 2);
      reset = 1'b1;
      rx    = 1'b1;
      exp_q.delete();
      exp_fe  = 1'b0;
      exp_ovf = 1'b0;
      idle(3);
      check_all_zero("t6_reset");
      reset = 1'b0;
      idle(BIT);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      idle(BIT);
      check("t6_count", fifo_count, exp_q.size());
      check("t6_data", data_out, 8'h3C);
      check("t6_fe", framing_error, exp_fe);
      drain("t6");

      // Randomized traffic with a draining reader
      rd_on = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if ($urandom_range(3, 0) == 0) begin
            @(negedge clk);
            rx = 1'b0;
            idle($urandom_range(60, 5));
            rx = 1'b1;
            idle(BIT);
         end
         send_frame(8'($urandom), $urandom_range(4, 0) != 0, 1'b0, 1'b0);
         idle($urandom_range(2 * BIT, BIT));
      end
      drain("rand");
      check("rand_fe", framing_error, exp_fe);
      check("rand_ovf", overflow, exp_ovf);
      check("rand_busy", busy, 0);
      clear_flags();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
